dce_loopback: RTL and testbench
===============================

// Module: dce_loopback
// PURPOSE
//  RS-232 DCE-side loopback endpoint (8N1 UART). Receives characters from the DTE on txd,
//  buffers them in a FIFO, and echoes them back on rxd in arrival order. Uses RTS/CTS
//  hardware flow control. Publishes its bit-period divisor (DBR) so the paired DTE UART
//  transactor can match its baud rate even when the two run from different clocks.
// PARAMETERS
//  CLKS_PER_BIT  87  clock cycles per UART bit (87 @ 10 MHz = ~115200 baud); must be >= 4
//  FIFO_DEPTH    16  echo buffer depth in bytes (power of 2, >= 8)
// PORTS
//  clock  in   1   single system clock; all logic on posedge
//  reset  in   1   asynchronous, active-high reset
//  rts    in   1   DTE request-to-send; 1 = DCE may start a character on rxd
//  cts    out  1   clear-to-send to DTE; 1 = DTE may send on txd
//  txd    in   1   serial data from DTE (idle = 1)
//  rxd    out  1   serial data to DTE (idle = 1)
//  DBR    out  32  constant CLKS_PER_BIT, zero-extended; driven even during reset
// BEHAVIOUR
//  Reset (async, immediate): rxd=1, cts=0; FIFO emptied; RX and TX FSMs to IDLE; any character in flight aborted.
//  txd passes through a 2-flop synchronizer before use; rts is sampled directly.
//  RX FSM IDLE->START->DATA->STOP:
//   - IDLE: a 1->0 transition on synced txd -> START, counter loaded.
//   - START: at CLKS_PER_BIT/2, if txd=1 it is a glitch -> IDLE; else -> DATA.
//   - DATA: 8 samples at bit centres (every CLKS_PER_BIT), LSB first.
//   - STOP: one sample at the stop-bit centre.
//     Stop=1: byte pushed to FIFO that cycle, unless FIFO full (byte dropped).
//     Stop=0: framing error, byte discarded.
//     Either way -> IDLE; a new start edge is accepted from the next cycle.
//  cts = 1 when FIFO occupancy <= FIFO_DEPTH-4, else 0; registered, so it updates one cycle after the occupancy change.
//  TX FSM IDLE->START->DATA->STOP:
//   - IDLE: leaves IDLE only when FIFO non-empty AND rts=1; pops the head byte that cycle.
//   - Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
//   - rxd is registered: first start-bit cycle begins 1 clock after the pop.
//   - rts dropping mid-character does not abort the frame; it only blocks the next one.
//   - After STOP, a new character may start next cycle (back-to-back, no extra idle).
//  Simultaneous RX push and TX pop in one cycle: both take effect, occupancy unchanged.
//  Push-to-rxd-start latency with rts=1 and FIFO empty: 2 clocks.
//  Counters are 32-bit; no arithmetic wraps within a character.
// CONFIGURATION
//  DCE_LOOPBACK_STATS_EN defined: adds output ports rx_count[15:0], tx_count[15:0], ferr_count[15:0].
//   - rx_count: bytes accepted into FIFO.
//   - tx_count: characters completed on rxd.
//   - ferr_count: framing errors plus overflow drops.
//   - All counters wrap at 16'hFFFF, reset to 0.
//  DCE_LOOPBACK_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package dce_loopback_pkg:
//   - uart_state_e enum {IDLE, START, DATA, STOP}
//   - DATA_BITS=8
//   - CTS_MARGIN=4
//  Sub-module dce_loopback_fifo: synchronous byte FIFO.
//   - Interface: push/pop/full/empty/count; async reset empties it.
//  RX FSM, TX FSM and CTS logic live in dce_loopback.
// TESTING
//  1. Reset held 20 cycles -> rxd=1, cts=0, DBR=87 throughout.
//     After release -> cts=1 within 2 clocks, rxd stays 1.
//  2. rts=1, DTE sends 0x55 -> identical 0x55 frame on rxd.
//     rxd start bit begins 2 clocks after the stop-bit centre sample; each bit is 87 cycles.
//  3. rts=0, DTE sends 0xA3, 0x00, 0xFF -> rxd stays 1.
//     Then raise rts -> A3, 00, FF echoed back-to-back, in order.
//  4. rts=0, send 13 bytes -> cts falls after the 13th push.
//     Send 17 total -> 17th dropped.
//     Raise rts -> exactly 16 bytes echoed; cts returns to 1 when occupancy <= 12.
//  5. txd low for 20 cycles only -> nothing echoed.
//     Frame 0x3C with stop bit 0 -> nothing echoed; next valid 0x3C echoed.
//  6. Assert reset mid-way through echoing 0x81 -> rxd=1 and cts=0 in the same cycle.
//     FIFO empty after release; no residual output.

Source files
------------

// File: rtl/dce_loopback_pkg.sv
// rtl/dce_loopback_pkg.sv - shared types and constants for the DCE loopback endpoint
package dce_loopback_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS  = 8;
    localparam int CTS_MARGIN = 4;

endpackage

// File: rtl/dce_loopback_fifo.sv
// rtl/dce_loopback_fifo.sv - synchronous first-word-fall-through byte FIFO, async reset empties it
module dce_loopback_fifo
    import dce_loopback_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_push,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_pop,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [AW:0]          o_count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full    = (r_count == FULL_COUNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dce_loopback.sv
// rtl/dce_loopback.sv - 8N1 UART loopback with RTS/CTS; DCE_LOOPBACK_STATS_EN adds rx/tx/ferr counters
module dce_loopback
    import dce_loopback_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rts,
    output logic        cts,
    input  logic        txd,
    output logic        rxd,
    output logic [31:0] DBR
`ifdef DCE_LOOPBACK_STATS_EN
    ,
    output logic [15:0] rx_count,
    output logic [15:0] tx_count,
    output logic [15:0] ferr_count
`endif
);

    localparam int              FAW       = $clog2(FIFO_DEPTH);
    localparam logic [31:0]     BIT_LAST  = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0]     HALF_LAST = 32'(CLKS_PER_BIT / 2 - 1);
    localparam logic [FAW:0]    CTS_LIMIT = (FAW+1)'(FIFO_DEPTH - CTS_MARGIN);
    localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 r_txd_s1, r_txd_s2, r_txd_s3;
    uart_state_e          r_rx_state;
    logic [31:0]          r_rx_cnt;
    logic [2:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    uart_state_e          r_tx_state;
    logic [31:0]          r_tx_cnt;
    logic [2:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_rxd;
    logic                 r_cts;

    logic                 w_rx_stop_sample, w_rx_push, w_fifo_push, w_tx_frame_end, w_pop;
    logic                 w_full, w_empty;
    logic [DATA_BITS-1:0] w_fifo_data;
    logic [FAW:0]         w_count;

    assign DBR = 32'(CLKS_PER_BIT);
    assign rxd = r_rxd;
    assign cts = r_cts;

    assign w_rx_stop_sample = (r_rx_state == STOP) && (r_rx_cnt == BIT_LAST);
    assign w_rx_push        = w_rx_stop_sample && r_txd_s2;
    assign w_fifo_push      = w_rx_push && !w_full;
    assign w_tx_frame_end   = (r_tx_state == STOP) && (r_tx_cnt == BIT_LAST);
    // Popping at the last stop-bit cycle lets the next frame follow with no idle gap.
    assign w_pop            = !w_empty && rts && ((r_tx_state == IDLE) || w_tx_frame_end);

    dce_loopback_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_fifo_push),
        .i_data  (r_rx_shift),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_txd_s1   <= 1'b1;
            r_txd_s2   <= 1'b1;
            r_txd_s3   <= 1'b1;
            r_rx_state <= IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_cts      <= 1'b0;
        end else begin
            r_txd_s1 <= txd;
            r_txd_s2 <= r_txd_s1;
            r_txd_s3 <= r_txd_s2;
            r_cts    <= (w_count <= CTS_LIMIT);
            case (r_rx_state)
                IDLE: if (r_txd_s3 && !r_txd_s2) begin
                    r_rx_state <= START;
                    r_rx_cnt   <= '0;
                end
                START: if (r_rx_cnt == HALF_LAST) begin
                    r_rx_cnt   <= '0;
                    r_rx_bit   <= '0;
                    r_rx_state <= r_txd_s2 ? IDLE : DATA;
                end else begin
                    r_rx_cnt <= r_rx_cnt + 32'd1;
                end
                DATA: if (r_rx_cnt == BIT_LAST) begin
                    r_rx_cnt   <= '0;
                    r_rx_shift <= {r_txd_s2, r_rx_shift[DATA_BITS-1:1]};
                    r_rx_bit   <= r_rx_bit + 3'd1;
                    if (r_rx_bit == LAST_BIT) r_rx_state <= STOP;
                end else begin
                    r_rx_cnt <= r_rx_cnt + 32'd1;
                end
                STOP: if (w_rx_stop_sample) begin
                    r_rx_cnt   <= '0;
                    r_rx_state <= IDLE;
                end else begin
                    r_rx_cnt <= r_rx_cnt + 32'd1;
                end
                default: r_rx_state <= IDLE;
            endcase
        end
    end

    // r_rxd carries the level of the state being occupied, so it lags the pop by one clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_rxd      <= 1'b1;
        end else begin
            case (r_tx_state)
                IDLE: begin
                    r_rxd <= 1'b1;
                    if (w_pop) begin
                        r_tx_state <= START;
                        r_tx_cnt   <= '0;
                        r_tx_shift <= w_fifo_data;
                    end
                end
                START: begin
                    r_rxd <= 1'b0;
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 32'd1;
                    end
                end
                DATA: begin
                    r_rxd <= r_tx_shift[0];
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
                        r_tx_bit   <= r_tx_bit + 3'd1;
                        if (r_tx_bit == LAST_BIT) r_tx_state <= STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 32'd1;
                    end
                end
                STOP: begin
                    r_rxd <= 1'b1;
                    if (w_tx_frame_end) begin
                        r_tx_cnt <= '0;
                        if (w_pop) begin
                            r_tx_state <= START;
                            r_tx_shift <= w_fifo_data;
                        end else begin
                            r_tx_state <= IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 32'd1;
                    end
                end
                default: r_tx_state <= IDLE;
            endcase
        end
    end

`ifdef DCE_LOOPBACK_STATS_EN
    logic [15:0] r_rx_count, r_tx_count, r_ferr_count;
    logic        w_rx_ferr;

    assign w_rx_ferr  = (w_rx_stop_sample && !r_txd_s2) || (w_rx_push && w_full);
    assign rx_count   = r_rx_count;
    assign tx_count   = r_tx_count;
    assign ferr_count = r_ferr_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_count   <= '0;
            r_tx_count   <= '0;
            r_ferr_count <= '0;
        end else begin
            if (w_fifo_push)    r_rx_count   <= r_rx_count + 16'd1;
            if (w_tx_frame_end) r_tx_count   <= r_tx_count + 16'd1;
            if (w_rx_ferr)      r_ferr_count <= r_ferr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dce_loopback.sv
// tb/tb_dce_loopback.sv - scoreboard bench for dce_loopback: directed frames, rxd monitor checks echoes
module tb_dce_loopback;

    localparam int CPB   = 87;
    localparam int FRAME = 10 * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rts   = 1'b0;
    logic        txd   = 1'b1;
    logic        cts;
    logic        rxd;
    logic [31:0] DBR;
`ifdef DCE_LOOPBACK_STATS_EN
    logic [15:0] rx_count, tx_count, ferr_count;
`endif

    int         cyc         = 0;
    int         n_checks    = 0;
    int         n_fail      = 0;
    int         frames_seen = 0;
    int         last_fall   = 0;
    bit         mon_busy    = 1'b0;
    logic [7:0] exp_q[$];

    dce_loopback #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .rts   (rts),
        .cts   (cts),
        .txd   (txd),
        .rxd   (rxd),
        .DBR   (DBR)
`ifdef DCE_LOOPBACK_STATS_EN
        ,
        .rx_count   (rx_count),
        .tx_count   (tx_count),
        .ferr_count (ferr_count)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, output int start_cyc);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(negedge clock);
        start_cyc = cyc;
        for (int k = 0; k < 10; k++) begin
            txd = f[k];
            repeat (CPB) @(negedge clock);
        end
        txd = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int limit, input string name);
        int t;
        t = 0;
        while (frames_seen < n && t < limit) begin
            @(negedge clock);
            t++;
        end
        if (frames_seen < n) check({name, "_timeout"}, frames_seen, n);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || mon_busy) && t < limit) begin
            @(negedge clock);
            t++;
        end
        if (exp_q.size() != 0 || mon_busy) check({name, "_idle_timeout"}, exp_q.size(), 0);
    endtask

    // Monitor: decode every frame on rxd cycle by cycle against the scoreboard head.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && rxd == 1'b0) begin
                logic [9:0] frame;
                logic [7:0] e;
                int         bad;
                bit         have;
                bit         aborted;
                frames_seen++;
                last_fall = cyc;
                mon_busy  = 1'b1;
                have      = (exp_q.size() > 0);
                e         = have ? exp_q.pop_front() : 8'h00;
                frame     = {1'b1, e, 1'b0};
                bad       = -1;
                aborted   = 1'b0;
                for (int i = 0; i < FRAME; i++) begin
                    if (i > 0) @(negedge clock);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (bad < 0 && rxd !== frame[i / CPB]) bad = i;
                end
                mon_busy = 1'b0;
                if (!aborted) begin
                    n_checks++;
                    if (!have) begin
                        n_fail++;
                        $display("FAIL echo_unexpected: frame on rxd, expected none");
                    end else if (bad >= 0) begin
                        n_fail++;
                        $display("FAIL echo_frame: byte 0x%0h first wrong rxd at frame cycle %0d, required bit %0b",
                                 e, bad, frame[bad / CPB]);
                    end
                end
            end
        end
    end

    initial begin
        int sc, f0, fa;

        // 1: reset held 20 cycles, then release
        repeat (20) begin
            @(negedge clock);
            check("reset_rxd", rxd, 1);
            check("reset_cts", cts, 0);
            check("reset_dbr", DBR, 87);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("release_cts", cts, 1);
        check("release_rxd", rxd, 1);
        check("release_dbr", DBR, 87);

        // 2: single echo and push-to-rxd latency
        rts = 1'b1;
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1, sc);
        wait_idle(2000, "t2");
        check("t2_latency_fall_cycle", last_fall, sc + 831);

        // 3: held by rts=0, then released back-to-back
        rts = 1'b0;
        f0  = frames_seen;
        exp_q.push_back(8'hA3); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        send_byte(8'hA3, 1'b1, sc);
        send_byte(8'h00, 1'b1, sc);
        send_byte(8'hFF, 1'b1, sc);
        repeat (200) @(negedge clock);
        check("t3_held_frames", frames_seen, f0);
        check("t3_held_rxd", rxd, 1);
        rts = 1'b1;
        wait_frames(f0 + 1, 100, "t3_first");
        fa = last_fall;
        wait_idle(4000, "t3");
        check("t3_frames", frames_seen, f0 + 3);
        check("t3_back_to_back_span", last_fall - fa, 2 * FRAME);

        // 4: fill to overflow, cts threshold both ways
        rts = 1'b0;
        f0  = frames_seen;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'h10 + 8'(i));
            send_byte(8'h10 + 8'(i), 1'b1, sc);
            if (i == 11) check("t4_cts_after_12", cts, 1);
            if (i == 12) check("t4_cts_after_13", cts, 0);
        end
        check("t4_cts_full", cts, 0);
        check("t4_held_frames", frames_seen, f0);
        rts = 1'b1;
        wait_frames(f0 + 3, 3000, "t4_f3");
        repeat (2) @(negedge clock);
        check("t4_cts_occ13", cts, 0);
        wait_frames(f0 + 4, 3000, "t4_f4");
        repeat (2) @(negedge clock);
        check("t4_cts_occ12", cts, 1);
        wait_idle(20000, "t4");
        repeat (1000) @(negedge clock);
        check("t4_echo_count", frames_seen, f0 + 16);

        // 5: start glitch and framing error are dropped
        f0 = frames_seen;
        @(negedge clock);
        txd = 1'b0;
        repeat (20) @(negedge clock);
        txd = 1'b1;
        repeat (200) @(negedge clock);
        check("t5_glitch_frames", frames_seen, f0);
        send_byte(8'h3C, 1'b0, sc);
        repeat (1000) @(negedge clock);
        check("t5_ferr_frames", frames_seen, f0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1, sc);
        wait_idle(2000, "t5");
        check("t5_good_frames", frames_seen, f0 + 1);

        // 6: async reset mid-echo flushes everything
        rts = 1'b0;
        f0  = frames_seen;
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1, sc);
        send_byte(8'h7E, 1'b1, sc);
        check("t6_cts_before", cts, 1);
        rts = 1'b1;
        wait_frames(f0 + 1, 100, "t6");
        repeat (300) @(negedge clock);
        check("t6_rxd_mid_frame", rxd, 0);
        #2 reset = 1'b1;
        #1;
        check("t6_reset_rxd", rxd, 1);
        check("t6_reset_cts", cts, 0);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("t6_release_cts", cts, 1);
        f0 = frames_seen;
        repeat (2500) @(negedge clock);
        check("t6_no_residual", frames_seen, f0);
        check("t6_rxd_idle", rxd, 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
